alarm_field_set: RTL and testbench

- Parametrised two-digit BCD setter for one alarm/clock field (hours, minutes or seconds). It is the clocked successor of the single-button hour setter.
- Supports increment and decrement, auto-repeat on button hold, configurable wrap limit and reset value, parallel load, and a wrap flag.
- Sits between the debounced button logic and the alarm compare/display path. One instance per field, e.g. MAX=23 for hours, MAX=59 for minutes.

---
 rtl/alarm_pkg.sv | 15 +
 rtl/btn_autorepeat.sv | 103 ++++++++++
 rtl/alarm_field_set.sv | 122 ++++++++++++
 tb/tb_alarm_field_set.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm field setters.
package alarm_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_NINE = 4'd9;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;

endpackage

// File: rtl/btn_autorepeat.sv
// Button edge detect plus hold/repeat FSM; step strobes are combinational for the current edge.
// Single step on press, then one after REPEAT_DELAY cycles, then every REPEAT_RATE cycles; no backpressure.
module btn_autorepeat
    import alarm_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000,
    parameter int unsigned CNT_W        = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic mode_alarm,
    input  logic btn_inc,
    input  logic btn_dec,
    input  logic clr,
    output logic step_inc,
    output logic step_dec
);

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc_prev_q, inc_prev_d;
    logic             dec_prev_q, dec_prev_d;
    logic             dir_q, dir_d;
    logic             armed_q, armed_d;

    logic inc_rise, dec_rise, held;

    assign inc_rise = btn_inc & ~inc_prev_q;
    assign dec_rise = btn_dec & ~dec_prev_q;
    assign held     = mode_alarm & (dir_q ? (btn_inc & ~btn_dec) : (btn_dec & ~btn_inc));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        inc_prev_d = btn_inc;
        dec_prev_d = btn_dec;
        armed_d    = 1'b1;
        step_inc   = 1'b0;
        step_dec   = 1'b0;

        if (clr || (btn_inc && btn_dec)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // armed_q blocks a button still held through reset from stepping
                    if (armed_q && mode_alarm && (inc_rise || dec_rise)) begin
                        step_inc = inc_rise;
                        step_dec = dec_rise;
                        dir_d    = inc_rise;
                        state_d  = ST_HOLD;
                        cnt_d    = '0;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (!held) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        // a direct switch to the other button is replayed as a fresh press next edge
                        if (mode_alarm && dir_q && btn_dec) dec_prev_d = 1'b0;
                        if (mode_alarm && !dir_q && btn_inc) inc_prev_d = 1'b0;
                    end else if (cnt_q == ((state_q == ST_HOLD) ? DELAY_LAST : RATE_LAST)) begin
                        step_inc = dir_q;
                        step_dec = ~dir_q;
                        state_d  = ST_REPEAT;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            inc_prev_q <= 1'b0;
            dec_prev_q <= 1'b0;
            dir_q      <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inc_prev_q <= inc_prev_d;
            dec_prev_q <= dec_prev_d;
            dir_q      <= dir_d;
            armed_q    <= armed_d;
        end
    end

endmodule

// File: rtl/alarm_field_set.sv
// Two-digit BCD alarm field with inc/dec auto-repeat, checked parallel load and wrap flag.
// Digits update on the deciding edge; wrap/load_err pulse for the following cycle; no backpressure.
module alarm_field_set
    import alarm_pkg::*;
#(
    parameter int unsigned MAX_TENS     = 2,
    parameter int unsigned MAX_ONES     = 3,
    parameter int unsigned RST_TENS     = 1,
    parameter int unsigned RST_ONES     = 2,
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000,
    parameter int unsigned CNT_W        = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_alarm,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] a_tens,
    output logic [3:0] a_ones,
    output logic       wrap,
    output logic       load_err
);

    localparam bcd_t MAX_T = bcd_t'(MAX_TENS);
    localparam bcd_t MAX_O = bcd_t'(MAX_ONES);
    localparam bcd_t RST_T = bcd_t'(RST_TENS);
    localparam bcd_t RST_O = bcd_t'(RST_ONES);

    if ((RST_TENS * 10 + RST_ONES) > (MAX_TENS * 10 + MAX_ONES) || RST_ONES > 9 || MAX_ONES > 9)
    begin : g_bad_reset_value
        $error("alarm_field_set: reset value must be valid BCD and not exceed MAX");
    end

    bcd_t tens_q, tens_d;
    bcd_t ones_q, ones_d;
    logic wrap_q, wrap_d;
    logic err_q, err_d;

    logic step_inc, step_dec;
    logic load_ok, at_max, at_zero;

    btn_autorepeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .CNT_W        (CNT_W)
    ) u_btn (
        .clk        (clk),
        .rst        (rst),
        .mode_alarm (mode_alarm),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .clr        (load),
        .step_inc   (step_inc),
        .step_dec   (step_dec)
    );

    assign load_ok = (load_tens <= BCD_NINE) && (load_ones <= BCD_NINE) &&
                     ((load_tens < MAX_T) || ((load_tens == MAX_T) && (load_ones <= MAX_O)));
    assign at_max  = (tens_q == MAX_T) && (ones_q == MAX_O);
    assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            if (load_ok) begin
                tens_d = load_tens;
                ones_d = load_ones;
            end else begin
                err_d = 1'b1;
            end
        end else if (step_inc) begin
            if (at_max) begin
                tens_d = 4'd0;
                ones_d = 4'd0;
                wrap_d = 1'b1;
            end else if (ones_q == BCD_NINE) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (step_dec) begin
            if (at_zero) begin
                tens_d = MAX_T;
                ones_d = MAX_O;
                wrap_d = 1'b1;
            end else if (ones_q == 4'd0) begin
                ones_d = BCD_NINE;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_q <= RST_T;
            ones_q <= RST_O;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign a_tens   = tens_q;
    assign a_ones   = ones_q;
    assign wrap     = wrap_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_alarm_field_set.sv
// Table-driven bench for alarm_field_set (MAX 23, reset 12, short repeat timing) with an expectation queue.
module tb_alarm_field_set;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_alarm, btn_inc, btn_dec, load;
    logic [3:0] load_tens, load_ones;
    logic [3:0] a_tens, a_ones;
    logic       wrap, load_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] t;
        logic [3:0] o;
        logic       w;
        logic       e;
    } exp_t;

    typedef struct {
        logic       ld;
        logic [3:0] lt;
        logic [3:0] lo;
        logic       inc;
        logic       dec;
        logic       mode;
        exp_t       ex;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[28];

    alarm_field_set #(
        .MAX_TENS     (2),
        .MAX_ONES     (3),
        .RST_TENS     (1),
        .RST_ONES     (2),
        .REPEAT_DELAY (4),
        .REPEAT_RATE  (2),
        .CNT_W        (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_alarm (mode_alarm),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .load       (load),
        .load_tens  (load_tens),
        .load_ones  (load_ones),
        .a_tens     (a_tens),
        .a_ones     (a_ones),
        .wrap       (wrap),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(input logic [3:0] t, input logic [3:0] o, input logic w, input logic e);
        exp_t r;
        r.t = t; r.o = o; r.w = w; r.e = e;
        return r;
    endfunction

    function automatic vec_t mk(input logic ld, input logic [3:0] lt, input logic [3:0] lo,
                                input logic inc, input logic dec, input logic mode, input exp_t e);
        vec_t v;
        v.ld = ld; v.lt = lt; v.lo = lo; v.inc = inc; v.dec = dec; v.mode = mode; v.ex = e;
        return v;
    endfunction

    task automatic compare_next(input string name);
        exp_t x;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        x = exp_q.pop_front();
        checks++;
        if ({a_tens, a_ones, wrap, load_err} !== {x.t, x.o, x.w, x.e}) begin
            errors++;
            $display("FAIL %s: got %0h%0h wrap=%b load_err=%b, expected %0h%0h wrap=%b load_err=%b",
                     name, a_tens, a_ones, wrap, load_err, x.t, x.o, x.w, x.e);
        end
    endtask

    task automatic run_cycle(input logic ld, input logic [3:0] lt, input logic [3:0] lo,
                             input logic inc, input logic dec, input logic mode,
                             input exp_t e, input string name);
        load = ld; load_tens = lt; load_ones = lo;
        btn_inc = inc; btn_dec = dec; mode_alarm = mode;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_next(name);
    endtask

    task automatic idle_cycle(input exp_t e, input string name);
        run_cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, e, name);
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 4'd2, 4'd3,  1'b0, 1'b0, 1'b1, ex(4'd2, 4'd3, 1'b0, 1'b0));
        vecs[1]  = mk(1'b0, 4'd0, 4'd0,  1'b1, 1'b0, 1'b1, ex(4'd0, 4'd0, 1'b1, 1'b0));
        vecs[2]  = mk(1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, ex(4'd0, 4'd0, 1'b0, 1'b0));
        vecs[3]  = mk(1'b1, 4'd0, 4'd9,  1'b0, 1'b0, 1'b1, ex(4'd0, 4'd9, 1'b0, 1'b0));
        vecs[4]  = mk(1'b0, 4'd0, 4'd0,  1'b1, 1'b0, 1'b1, ex(4'd1, 4'd0, 1'b0, 1'b0));
        vecs[5]  = mk(1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, ex(4'd1, 4'd0, 1'b0, 1'b0));
        vecs[6]  = mk(1'b0, 4'd0, 4'd0,  1'b0, 1'b1, 1'b1, ex(4'd0, 4'd9, 1'b0, 1'b0));
        vecs[7]  = mk(1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, ex(4'd0, 4'd9, 1'b0, 1'b0));
        vecs[8]  = mk(1'b1, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, ex(4'd0, 4'd0, 1'b0, 1'b0));
        vecs[9]  = mk(1'b0, 4'd0, 4'd0,  1'b0, 1'b1, 1'b1, ex(4'd2, 4'd3, 1'b1, 1'b0));
        vecs[10] = mk(1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, ex(4'd2, 4'd3, 1'b0, 1'b0));
        vecs[11] = mk(1'b1, 4'd2, 4'd4,  1'b0, 1'b0, 1'b1, ex(4'd2, 4'd3, 1'b0, 1'b1));
        vecs[12] = mk(1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, ex(4'd2, 4'd3, 1'b0, 1'b0));
        vecs[13] = mk(1'b1, 4'd1, 4'hA,  1'b0, 1'b0, 1'b1, ex(4'd2, 4'd3, 1'b0, 1'b1));
        vecs[14] = mk(1'b1, 4'd1, 4'd5,  1'b0, 1'b0, 1'b1, ex(4'd1, 4'd5, 1'b0, 1'b0));
        vecs[15] = mk(1'b1, 4'd1, 4'd5,  1'b1, 1'b0, 1'b1, ex(4'd1, 4'd5, 1'b0, 1'b0));
        vecs[16] = mk(1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, ex(4'd1, 4'd5, 1'b0, 1'b0));
        vecs[17] = mk(1'b0, 4'd0, 4'd0,  1'b1, 1'b0, 1'b0, ex(4'd1, 4'd5, 1'b0, 1'b0));
        vecs[18] = mk(1'b0, 4'd0, 4'd0,  1'b1, 1'b0, 1'b1, ex(4'd1, 4'd5, 1'b0, 1'b0));
        vecs[19] = mk(1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, ex(4'd1, 4'd5, 1'b0, 1'b0));
        vecs[20] = mk(1'b0, 4'd0, 4'd0,  1'b1, 1'b0, 1'b1, ex(4'd1, 4'd6, 1'b0, 1'b0));
        vecs[21] = mk(1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, ex(4'd1, 4'd6, 1'b0, 1'b0));
        vecs[22] = mk(1'b0, 4'd0, 4'd0,  1'b1, 1'b1, 1'b1, ex(4'd1, 4'd6, 1'b0, 1'b0));
        vecs[23] = mk(1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, ex(4'd1, 4'd6, 1'b0, 1'b0));
        vecs[24] = mk(1'b1, 4'd2, 4'd0,  1'b0, 1'b0, 1'b1, ex(4'd2, 4'd0, 1'b0, 1'b0));
        vecs[25] = mk(1'b0, 4'd0, 4'd0,  1'b0, 1'b1, 1'b1, ex(4'd1, 4'd9, 1'b0, 1'b0));
        vecs[26] = mk(1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, ex(4'd1, 4'd9, 1'b0, 1'b0));
        vecs[27] = mk(1'b1, 4'd3, 4'd0,  1'b0, 1'b0, 1'b1, ex(4'd1, 4'd9, 1'b0, 1'b1));

        rst = 1'b1;
        mode_alarm = 1'b1; btn_inc = 1'b0; btn_dec = 1'b0;
        load = 1'b0; load_tens = 4'd0; load_ones = 4'd0;
        #12;
        exp_q.push_back(ex(4'd1, 4'd2, 1'b0, 1'b0));
        compare_next("reset_value");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(ex(4'd1, 4'd2, 1'b0, 1'b0));
        compare_next("after_reset_release");

        foreach (vecs[i]) begin
            run_cycle(vecs[i].ld, vecs[i].lt, vecs[i].lo, vecs[i].inc, vecs[i].dec, vecs[i].mode,
                      vecs[i].ex, $sformatf("vec%0d", i));
        end

        // Auto-repeat: step on press, after 4 more cycles, then every 2 cycles.
        run_cycle(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, ex(4'd0, 4'd0, 1'b0, 1'b0), "rpt_load");
        for (int i = 0; i < 10; i++) begin
            int n;
            n = 1 + (i >= 4 ? 1 : 0) + (i >= 6 ? 1 : 0) + (i >= 8 ? 1 : 0);
            run_cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, ex(4'd0, 4'(n), 1'b0, 1'b0),
                      $sformatf("rpt_hold%0d", i));
        end
        for (int i = 0; i < 3; i++)
            idle_cycle(ex(4'd0, 4'd4, 1'b0, 1'b0), $sformatf("rpt_release%0d", i));

        // Direct switch from held inc to dec steps dec one edge later.
        run_cycle(1'b1, 4'd1, 4'd5, 1'b0, 1'b0, 1'b1, ex(4'd1, 4'd5, 1'b0, 1'b0), "sw_load");
        run_cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, ex(4'd1, 4'd6, 1'b0, 1'b0), "sw_inc");
        run_cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, ex(4'd1, 4'd6, 1'b0, 1'b0), "sw_hold");
        run_cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, ex(4'd1, 4'd6, 1'b0, 1'b0), "sw_switch");
        run_cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, ex(4'd1, 4'd5, 1'b0, 1'b0), "sw_dec_step");
        idle_cycle(ex(4'd1, 4'd5, 1'b0, 1'b0), "sw_release");

        // Reset while repeating with inc held.
        run_cycle(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, ex(4'd0, 4'd0, 1'b0, 1'b0), "rr_load");
        for (int i = 0; i < 7; i++) begin
            int n;
            n = 1 + (i >= 4 ? 1 : 0) + (i >= 6 ? 1 : 0);
            run_cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, ex(4'd0, 4'(n), 1'b0, 1'b0),
                      $sformatf("rr_hold%0d", i));
        end
        #2 rst = 1'b1;
        #1;
        exp_q.push_back(ex(4'd1, 4'd2, 1'b0, 1'b0));
        compare_next("rr_async_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            run_cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, ex(4'd1, 4'd2, 1'b0, 1'b0),
                      $sformatf("rr_still_held%0d", i));
        idle_cycle(ex(4'd1, 4'd2, 1'b0, 1'b0), "rr_release");
        run_cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, ex(4'd1, 4'd3, 1'b0, 1'b0), "rr_repress");
        idle_cycle(ex(4'd1, 4'd3, 1'b0, 1'b0), "rr_final");

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
